// File: rtl/paicore_pkg.sv
// Shared types for the PAICORE multi-channel sender: channel FSM states and
// the words-per-beat helper used to size per-channel word counters.
package paicore_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_REQ  = 2'd1,
    CH_REL  = 2'd2
  } ch_state_e;

  function automatic int words_per_beat(input int dw, input int pw);
    return dw / pw;
  endfunction

endpackage

// File: rtl/paicore_send_ch.sv
// One four-phase request/acknowledge channel: holds a beat and sends it MSW first.
// Optional acknowledge watchdog enabled by PAICORE_SEND_TIMEOUT_EN.
module paicore_send_ch
  import paicore_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int PW          = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] beat_i,
  input  logic                  ack_s_i,
  output logic                  req_o,
  output logic [PW-1:0]         dout_o,
  output logic                  idle_o,
  output logic                  tmo_o
);

  localparam int WPB = words_per_beat(DATA_WIDTH, PW);
  localparam int WCW = (WPB > 1) ? $clog2(WPB) : 1;

  ch_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] beat_q, beat_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic                  tmo_fire;

`ifdef PAICORE_SEND_TIMEOUT_EN
  // Counts cycles spent in the current handshake phase; restarts on every transition.
  logic [31:0] wd_q, wd_d;
  assign tmo_fire = (state_q != CH_IDLE) && (wd_q == 32'(TIMEOUT_CYC - 1));
  always_comb wd_d = (state_q == CH_IDLE || state_d != state_q) ? '0 : wd_q + 32'd1;
  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_IDLE;
      beat_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      CH_IDLE: if (load_i) begin
        beat_d  = beat_i;
        wcnt_d  = '0;
        state_d = CH_REQ;
      end
      CH_REQ: if (ack_s_i) state_d = CH_REL;
      CH_REL: if (!ack_s_i) begin
        if (wcnt_q == WCW'(WPB - 1)) begin
          state_d = CH_IDLE;
        end else begin
          // Next word moves into the top slot that drives dout.
          beat_d  = beat_q << PW;
          wcnt_d  = wcnt_q + WCW'(1);
          state_d = CH_REQ;
        end
      end
      default: state_d = CH_IDLE;
    endcase
    if (tmo_fire) state_d = CH_IDLE;
  end

  always_comb begin
    req_o  = (state_q == CH_REQ);
    idle_o = (state_q == CH_IDLE);
    dout_o = beat_q[DATA_WIDTH-1 -: PW];
    tmo_o  = tmo_fire;
  end

endmodule

// File: rtl/paicore_send_mc.sv
// AXI-Stream to CH-way four-phase handshake sender with round-robin beat dispatch.
// Define PAICORE_SEND_TIMEOUT_EN to enable per-channel ack watchdog and err flags.
module paicore_send_mc
  import paicore_pkg::*;
#(
  parameter int CH          = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int PW          = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         ch_mask,
  input  logic [31:0]           send_len,
  input  logic                  i_clr,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [CH-1:0]         request,
  output logic [CH*PW-1:0]      dout,
  input  logic [CH-1:0]         acknowledge,
  output logic [31:0]           data_cnt,
  output logic [31:0]           tlast_cnt,
  output logic                  o_tx_done,
  output logic [CH-1:0]         err
);

  localparam int PTR_W = (CH > 1) ? $clog2(CH) : 1;

  // Nearest set mask bit strictly after 'from', wrapping; 'from' itself is the last resort.
  function automatic logic [PTR_W-1:0] next_set(input logic [CH-1:0] m, input logic [PTR_W-1:0] from);
    int idx;
    next_set = from;
    for (int k = CH; k >= 1; k--) begin
      idx = (int'(from) + k) % CH;
      if (m[idx]) next_set = PTR_W'(idx);
    end
  endfunction

  logic [CH-1:0]    ack_m_q, ack_s_q, idle, tmo;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [31:0]      data_cnt_q, tlast_cnt_q;
  logic             fired_q, done_q, done_d, accept;

  assign s_axis_tready = !rst && (|ch_mask) && ch_mask[ptr_q] && idle[ptr_q];
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    ptr_d = ptr_q;
    if (accept || ((|ch_mask) && !ch_mask[ptr_q])) ptr_d = next_set(ch_mask, ptr_q);
  end

  assign done_d = !fired_q && !i_clr && (send_len != 32'd0) && (data_cnt_q == send_len) && (&idle);

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_m_q     <= '0;
      ack_s_q     <= '0;
      ptr_q       <= next_set(ch_mask, PTR_W'(CH - 1));
      data_cnt_q  <= '0;
      tlast_cnt_q <= '0;
      fired_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ack_m_q <= acknowledge;
      ack_s_q <= ack_m_q;
      ptr_q   <= ptr_d;
      if (i_clr) begin
        data_cnt_q  <= {31'd0, accept};
        tlast_cnt_q <= {31'd0, accept && s_axis_tlast};
      end else begin
        if (accept)                 data_cnt_q  <= data_cnt_q + 32'd1;
        if (accept && s_axis_tlast) tlast_cnt_q <= tlast_cnt_q + 32'd1;
      end
      fired_q <= i_clr ? 1'b0 : (fired_q | done_d);
      done_q  <= done_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    paicore_send_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .PW         (PW),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept && (ptr_q == PTR_W'(g))),
      .beat_i (s_axis_tdata),
      .ack_s_i(ack_s_q[g]),
      .req_o  (request[g]),
      .dout_o (dout[g*PW +: PW]),
      .idle_o (idle[g]),
      .tmo_o  (tmo[g])
    );
  end

`ifdef PAICORE_SEND_TIMEOUT_EN
  logic [CH-1:0] err_q;
  always_ff @(posedge clk) begin
    if (rst)        err_q <= '0;
    else if (i_clr) err_q <= tmo;
    else            err_q <= err_q | tmo;
  end
  assign err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = |tmo;
  assign err        = '0;
`endif

  assign data_cnt  = data_cnt_q;
  assign tlast_cnt = tlast_cnt_q;
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_paicore_send_mc.sv
// Randomized self-checking bench for paicore_send_mc (CH=4, 64-bit beats, 32-bit words).
module tb_paicore_send_mc;

  localparam int CH = 4;
  localparam int DW = 64;
  localparam int PW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] ch_mask = '1;
  logic [31:0]   send_len = '0;
  logic          i_clr = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          tready;
  logic [CH-1:0] request;
  logic [CH*PW-1:0] dout;
  logic [CH-1:0] acknowledge = '0;
  logic [31:0]   data_cnt, tlast_cnt;
  logic          o_tx_done;
  logic [CH-1:0] err;

  int checks = 0;
  int passed = 0;

  paicore_send_mc #(.CH(CH), .DATA_WIDTH(DW), .PW(PW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ch_mask(ch_mask), .send_len(send_len), .i_clr(i_clr),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready),
    .request(request), .dout(dout), .acknowledge(acknowledge),
    .data_cnt(data_cnt), .tlast_cnt(tlast_cnt), .o_tx_done(o_tx_done), .err(err)
  );

  always #5 clk = ~clk;

  // Peer responder: mirrors request into acknowledge, optionally with random lag.
  logic [CH-1:0] noack = '0;
  bit            fast = 1'b1;
  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (noack[c])                             acknowledge[c] <= 1'b0;
      else if (fast || $urandom_range(0, 3) != 0) acknowledge[c] <= request[c];
    end
  end

  // Monitor: captures the word presented at every request rise.
  logic [31:0]      obs_q [CH][$];
  logic [31:0]      exp_q [CH][$];
  logic [CH-1:0]    prev_req = '0;
  logic [CH*PW-1:0] prev_dout = '0;
  int done_cnt = 0, done_busy = 0, stab_err = 0;
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (request[c] && !prev_req[c]) obs_q[c].push_back(dout[c*PW +: PW]);
      if (request[c] && prev_req[c] && dout[c*PW +: PW] !== prev_dout[c*PW +: PW]) stab_err <= stab_err + 1;
    end
    if (o_tx_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      if (request != '0) done_busy <= done_busy + 1;
    end
    prev_req  <= request;
    prev_dout <= dout;
  end

  task automatic clear_q();
    for (int c = 0; c < CH; c++) begin
      obs_q[c].delete();
      exp_q[c].delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tvalid = 1'b0; i_clr = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    bit ok = 1'b0;
    int n = 0;
    tvalid = 1'b1; tdata = d; tlast = l;
    while (!ok && n < 500) begin
      @(negedge clk);
      if (tready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    tvalid = 1'b0; tlast = 1'b0;
    checks++;
    if (!ok) $display("FAIL send_beat: beat %h not accepted, got tready=%b want 1 within 500 cycles", d, tready);
    else passed++;
  endtask

  task automatic wait_drain(input string tag);
    int quiet = 0, n = 0;
    while (quiet < 12 && n < 3000) begin
      @(negedge clk);
      if (request == '0 && acknowledge == '0) quiet++;
      else quiet = 0;
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (quiet < 12) $display("FAIL %s drain: request=%b still busy, want idle", tag, request);
    else passed++;
  endtask

  task automatic test_reset();
    ch_mask = 4'hF;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (request !== '0)     $display("FAIL reset request got %b want 0", request); else passed++;
    checks++; if (dout !== '0)        $display("FAIL reset dout got %h want 0", dout); else passed++;
    checks++; if (tready !== 1'b0)    $display("FAIL reset tready got %b want 0", tready); else passed++;
    checks++; if (data_cnt !== 32'd0) $display("FAIL reset data_cnt got %0d want 0", data_cnt); else passed++;
    checks++; if (tlast_cnt !== 32'd0) $display("FAIL reset tlast_cnt got %0d want 0", tlast_cnt); else passed++;
    checks++; if (o_tx_done !== 1'b0) $display("FAIL reset o_tx_done got %b want 0", o_tx_done); else passed++;
    checks++; if (err !== '0)         $display("FAIL reset err got %b want 0", err); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tready !== 1'b1)    $display("FAIL post-reset tready got %b want 1", tready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_rotation();
    int lst[$];
    int nb, ntl, ch;
    logic [DW-1:0] d;
    logic l;
    for (int r = 0; r < 7; r++) begin
      // Round 0 is the fixed 8-beat all-channel case; later rounds are random.
      ch_mask = (r == 0) ? 4'hF : 4'($urandom_range(1, 15));
      fast    = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      nb      = (r == 0) ? 8 : $urandom_range(3, 12);
      do_reset();
      clear_q();
      lst.delete();
      for (int c = 0; c < CH; c++) if (ch_mask[c]) lst.push_back(c);
      ntl = 0;
      for (int k = 0; k < nb; k++) begin
        if (r == 0) begin
          d = {32'(k), 32'hB000_0000 | 32'(k)};
          l = (k == nb - 1);
        end else begin
          d = {$urandom, $urandom};
          l = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        ch = lst[k % lst.size()];
        exp_q[ch].push_back(d[DW-1 -: PW]);
        exp_q[ch].push_back(d[PW-1:0]);
        if (l) ntl++;
        send_beat(d, l);
      end
      wait_drain("rotation");
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (obs_q[c].size() != exp_q[c].size())
          $display("FAIL rot%0d words ch%0d got %0d want %0d (mask %b)", r, c, obs_q[c].size(), exp_q[c].size(), ch_mask);
        else passed++;
        for (int i = 0; i < exp_q[c].size() && i < obs_q[c].size(); i++) begin
          checks++;
          if (obs_q[c][i] !== exp_q[c][i])
            $display("FAIL rot%0d word ch%0d[%0d] got %h want %h", r, c, i, obs_q[c][i], exp_q[c][i]);
          else passed++;
        end
      end
      checks++; if (data_cnt !== 32'(nb))   $display("FAIL rot%0d data_cnt got %0d want %0d", r, data_cnt, nb); else passed++;
      checks++; if (tlast_cnt !== 32'(ntl)) $display("FAIL rot%0d tlast_cnt got %0d want %0d", r, tlast_cnt, ntl); else passed++;
    end
    checks++; if (stab_err !== 0) $display("FAIL dout_stable got %0d changes want 0", stab_err); else passed++;
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    ch_mask = 4'b0100;
    fast = 1'b0;
    do_reset();
    clear_q();
    for (int k = 0; k < 3; k++) begin
      d = {$urandom, $urandom};
      exp_q[2].push_back(d[DW-1 -: PW]);
      exp_q[2].push_back(d[PW-1:0]);
      send_beat(d, 1'b0);
    end
    wait_drain("single");
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (obs_q[c].size() != exp_q[c].size())
        $display("FAIL single words ch%0d got %0d want %0d", c, obs_q[c].size(), exp_q[c].size());
      else passed++;
    end
    for (int i = 0; i < exp_q[2].size() && i < obs_q[2].size(); i++) begin
      checks++;
      if (obs_q[2][i] !== exp_q[2][i]) $display("FAIL single word[%0d] got %h want %h", i, obs_q[2][i], exp_q[2][i]);
      else passed++;
    end
  endtask

  task automatic test_done();
    int base, bbase;
    ch_mask = 4'hF;
    fast = 1'b0;
    do_reset();
    send_len = 32'd5;
    base = done_cnt; bbase = done_busy;
    for (int k = 0; k < 5; k++) send_beat({$urandom, $urandom}, k == 4);
    wait_drain("done");
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (done_cnt - base !== 1)   $display("FAIL done pulses got %0d want 1", done_cnt - base); else passed++;
    checks++; if (done_busy !== bbase)     $display("FAIL done while busy got %0d want %0d", done_busy, bbase); else passed++;
    checks++; if (data_cnt !== 32'd5)      $display("FAIL done data_cnt got %0d want 5", data_cnt); else passed++;
    checks++; if (tlast_cnt !== 32'd1)     $display("FAIL done tlast_cnt got %0d want 1", tlast_cnt); else passed++;
    // Clear coinciding with an accepted beat leaves that beat counted.
    tvalid = 1'b1; tdata = {$urandom, $urandom}; tlast = 1'b0; i_clr = 1'b1;
    @(negedge clk);
    checks++; if (tready !== 1'b1) $display("FAIL clr_beat tready got %b want 1", tready); else passed++;
    @(posedge clk); #1;
    tvalid = 1'b0; i_clr = 1'b0;
    @(negedge clk);
    checks++; if (data_cnt !== 32'd1)  $display("FAIL clr data_cnt got %0d want 1", data_cnt); else passed++;
    checks++; if (tlast_cnt !== 32'd0) $display("FAIL clr tlast_cnt got %0d want 0", tlast_cnt); else passed++;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) send_beat({$urandom, $urandom}, 1'b0);
    wait_drain("done2");
    checks++; if (done_cnt - base !== 2) $display("FAIL rearm pulses got %0d want 2", done_cnt - base); else passed++;
    checks++; if (data_cnt !== 32'd5)    $display("FAIL rearm data_cnt got %0d want 5", data_cnt); else passed++;
    send_len = 32'd0;
  endtask

  task automatic test_mask_zero();
    int hi = 0;
    ch_mask = '0;
    tvalid = 1'b1; tdata = {$urandom, $urandom}; tlast = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (tready !== 1'b0) hi++;
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0;
    @(negedge clk);
    checks++; if (hi !== 0)             $display("FAIL mask0 tready got %0d high cycles want 0", hi); else passed++;
    checks++; if (data_cnt !== 32'd5)   $display("FAIL mask0 data_cnt got %0d want 5", data_cnt); else passed++;
    checks++; if (tlast_cnt !== 32'd0)  $display("FAIL mask0 tlast_cnt got %0d want 0", tlast_cnt); else passed++;
    checks++; if (request !== '0)       $display("FAIL mask0 request got %b want 0", request); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    ch_mask = 4'b0001;
    fast = 1'b1;
    do_reset();
    noack[0] = 1'b1;
    send_beat({$urandom, $urandom}, 1'b0);
    while (request[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (request[0] !== 1'b1) $display("FAIL rstmid request[0] got %b want 1", request[0]); else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tready !== 1'b0) $display("FAIL rstmid tready got %b want 0", tready); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (request !== '0)     $display("FAIL rstmid request got %b want 0", request); else passed++;
    checks++; if (data_cnt !== 32'd0) $display("FAIL rstmid data_cnt got %0d want 0", data_cnt); else passed++;
    checks++; if (dout !== '0)        $display("FAIL rstmid dout got %h want 0", dout); else passed++;
    checks++; if (tready !== 1'b0)    $display("FAIL rstmid tready2 got %b want 0", tready); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    noack = '0;
    wait_drain("rstmid");
  endtask

  task automatic test_timeout();
    logic [DW-1:0] d1, d2;
    int n = 0, hi = 0;
    ch_mask = 4'b0010;
    fast = 1'b1;
    do_reset();
    clear_q();
    noack[1] = 1'b1;
    d1 = {$urandom, $urandom};
    send_beat(d1, 1'b0);
`ifdef PAICORE_SEND_TIMEOUT_EN
    while (request[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    while (request[1] === 1'b1 && hi < 200) begin hi++; @(negedge clk); end
    checks++; if (hi !== TO)     $display("FAIL timeout request high got %0d cycles want %0d", hi, TO); else passed++;
    checks++; if (err !== 4'b0010) $display("FAIL timeout err got %b want 0010", err); else passed++;
    @(posedge clk); #1;
    noack = '0;
    d2 = {$urandom, $urandom};
    send_beat(d2, 1'b0);
    wait_drain("timeout");
    exp_q[1].push_back(d1[DW-1 -: PW]);
    exp_q[1].push_back(d2[DW-1 -: PW]);
    exp_q[1].push_back(d2[PW-1:0]);
    checks++; if (err !== 4'b0010) $display("FAIL timeout err sticky got %b want 0010", err); else passed++;
    i_clr = 1'b1; @(posedge clk); #1; i_clr = 1'b0;
    @(negedge clk);
    checks++; if (err !== '0) $display("FAIL timeout err clr got %b want 0", err); else passed++;
    @(posedge clk); #1;
`else
    repeat (3 * TO) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if (request[1] !== 1'b1) $display("FAIL nowd request[1] got %b want 1", request[1]); else passed++;
    checks++; if (err !== '0)          $display("FAIL nowd err got %b want 0", err); else passed++;
    @(posedge clk); #1;
    noack = '0;
    wait_drain("nowd");
    exp_q[1].push_back(d1[DW-1 -: PW]);
    exp_q[1].push_back(d1[PW-1:0]);
    d2 = '0;
    checks++; if (err !== '0) $display("FAIL nowd err after got %b want 0 (%h)", err, d2); else passed++;
`endif
    checks++;
    if (obs_q[1].size() != exp_q[1].size()) $display("FAIL timeout words got %0d want %0d", obs_q[1].size(), exp_q[1].size());
    else passed++;
    for (int i = 0; i < exp_q[1].size() && i < obs_q[1].size(); i++) begin
      checks++;
      if (obs_q[1][i] !== exp_q[1][i]) $display("FAIL timeout word[%0d] got %h want %h", i, obs_q[1][i], exp_q[1][i]);
      else passed++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_rotation();
    test_single();
    test_done();
    test_mask_zero();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
